// File: rtl/dcpu16_wbarb_if.sv
// rtl/dcpu16_wbarb_if.sv - requester and memory bus bundle for the N-channel arbiter
interface dcpu16_wbarb_if #(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int NCH = 2
);
    logic [NCH*AW-1:0] c_adr;
    logic [NCH-1:0]    c_stb;
    logic [NCH-1:0]    c_wre;
    logic [NCH*DW-1:0] c_dto;
    logic [DW-1:0]     c_dti;
    logic [NCH-1:0]    c_ack;
    logic [NCH-1:0]    c_err;
    logic [AW-1:0]     m_adr;
    logic              m_stb;
    logic              m_wre;
    logic [DW-1:0]     m_dto;
    logic [DW-1:0]     m_dti;
    logic              m_ack;
    logic [NCH-1:0]    gnt;
    logic              ena;

    // slave: the arbiter itself; master: requesters plus memory environment
    modport slave (
        input  c_adr, c_stb, c_wre, c_dto, m_dti, m_ack,
        output c_dti, c_ack, c_err, m_adr, m_stb, m_wre, m_dto, gnt, ena
    );
    modport master (
        output c_adr, c_stb, c_wre, c_dto, m_dti, m_ack,
        input  c_dti, c_ack, c_err, m_adr, m_stb, m_wre, m_dto, gnt, ena
    );
endinterface

// File: rtl/dcpu16_wbarb.sv
// rtl/dcpu16_wbarb.sv - N-channel Wishbone arbiter with round-robin/fixed priority and timeout
module dcpu16_wbarb #(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int NCH = 2,
    parameter int RR  = 1,
    parameter int TMO = 0
) (
    input  logic          clk,
    input  logic          rst,
    dcpu16_wbarb_if.slave bus
);
    localparam int GW = $clog2(NCH);
    localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TMO > 0) ? (TMO - 1) : 0);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [NCH-1:0]  gnt_q, gnt_d;
    logic [GW-1:0]   gidx_q, gidx_d;
    logic [GW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   m_adr_q, m_adr_d;
    logic            m_stb_q, m_stb_d;
    logic            m_wre_q, m_wre_d;
    logic [DW-1:0]   m_dto_q, m_dto_d;
    logic [DW-1:0]   c_dti_q, c_dti_d;
    logic [NCH-1:0]  c_ack_q, c_ack_d;
    logic [NCH-1:0]  c_err_q, c_err_d;

    logic            win_found;
    logic [GW-1:0]   win_idx;
    logic [GW-1:0]   cand;

    // Scan order starts just past the last served channel in round-robin mode
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NCH; i++) begin
            if (RR != 0) cand = GW'((int'(last_q) + 1 + i) % NCH);
            else         cand = GW'(i);
            if (!win_found && bus.c_stb[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        m_adr_d = m_adr_q;
        m_stb_d = m_stb_q;
        m_wre_d = m_wre_q;
        m_dto_d = m_dto_q;
        c_dti_d = c_dti_q;
        c_ack_d = '0;
        c_err_d = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gidx_d          = win_idx;
                    gnt_d           = '0;
                    gnt_d[win_idx]  = 1'b1;
                    m_adr_d         = bus.c_adr[int'(win_idx)*AW +: AW];
                    m_wre_d         = bus.c_wre[win_idx];
                    m_dto_d         = bus.c_dto[int'(win_idx)*DW +: DW];
                    m_stb_d         = 1'b1;
                    cnt_d           = '0;
                    state_d         = BUSY;
                end
            end
            BUSY: begin
                // A slave ack in the final timeout cycle still wins over the error
                if (bus.m_ack) begin
                    if (!m_wre_q) c_dti_d = bus.m_dti;
                    c_ack_d = gnt_q;
                    m_stb_d = 1'b0;
                    last_d  = gidx_q;
                    state_d = DONE;
                end else if (TMO != 0 && cnt_q == CNT_LAST) begin
                    c_err_d = gnt_q;
                    m_stb_d = 1'b0;
                    last_d  = gidx_q;
                    state_d = DONE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            last_q  <= GW'(NCH - 1);
            cnt_q   <= '0;
            m_adr_q <= '0;
            m_stb_q <= 1'b0;
            m_wre_q <= 1'b0;
            m_dto_q <= '0;
            c_dti_q <= '0;
            c_ack_q <= '0;
            c_err_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            m_adr_q <= m_adr_d;
            m_stb_q <= m_stb_d;
            m_wre_q <= m_wre_d;
            m_dto_q <= m_dto_d;
            c_dti_q <= c_dti_d;
            c_ack_q <= c_ack_d;
            c_err_q <= c_err_d;
        end
    end

    assign bus.c_dti = c_dti_q;
    assign bus.c_ack = c_ack_q;
    assign bus.c_err = c_err_q;
    assign bus.m_adr = m_adr_q;
    assign bus.m_stb = m_stb_q;
    assign bus.m_wre = m_wre_q;
    assign bus.m_dto = m_dto_q;
    assign bus.gnt   = gnt_q;
    assign bus.ena   = &(~bus.c_stb | c_ack_q | c_err_q);
endmodule

// File: tb/tb_dcpu16_wbarb.sv
// tb/tb_dcpu16_wbarb.sv - self-checking bench for the dcpu16_wbarb arbiter
module tb_dcpu16_wbarb;
    localparam int AW = 16, DW = 16, NCH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dcpu16_wbarb_if #(.AW(AW), .DW(DW), .NCH(NCH)) ifa ();
    dcpu16_wbarb_if #(.AW(AW), .DW(DW), .NCH(NCH)) ifb ();

    dcpu16_wbarb #(.AW(AW), .DW(DW), .NCH(NCH), .RR(1), .TMO(4)) dut (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    dcpu16_wbarb #(.AW(AW), .DW(DW), .NCH(NCH), .RR(0), .TMO(0)) dut_fp (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    logic [1:0]  req_stb = 2'b00;
    logic [1:0]  req_wre = 2'b00;
    logic [15:0] req_adr [2];
    logic [15:0] req_dto [2];
    logic        m_ack_s = 1'b0;
    logic        ack_force = 1'b0;
    logic [15:0] m_dti_s = 16'h0;
    logic [15:0] smem [256];
    logic [15:0] ref_mem [256];
    int          cur_dly = 0;
    int          wait_cnt = 0;
    bit          rand_dly = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;

    assign ifa.c_stb = req_stb;
    assign ifa.c_wre = req_wre;
    assign ifa.c_adr = {req_adr[1], req_adr[0]};
    assign ifa.c_dto = {req_dto[1], req_dto[0]};
    assign ifa.m_ack = m_ack_s | ack_force;
    assign ifa.m_dti = m_dti_s;
    assign ifb.c_stb = ifa.c_stb;
    assign ifb.c_wre = ifa.c_wre;
    assign ifb.c_adr = ifa.c_adr;
    assign ifb.c_dto = ifa.c_dto;
    assign ifb.m_ack = ifb.m_stb;
    assign ifb.m_dti = 16'h5A5A;

    typedef struct {
        int          ch;
        logic        wre;
        logic [15:0] adr;
        logic [15:0] dto;
        int          dly;
        logic        err;
        logic [15:0] dti;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Memory slave: acks cur_dly cycles after it first sees m_stb
    task automatic tick();
        @(negedge clk);
        if (ifa.m_stb) begin
            if (wait_cnt == 0 && rand_dly) cur_dly = $urandom_range(0, 5);
            if (wait_cnt == cur_dly) begin
                m_ack_s = 1'b1;
                if (ifa.m_wre) smem[ifa.m_adr[7:0]] = ifa.m_dto;
                else           m_dti_s = smem[ifa.m_adr[7:0]];
            end else begin
                m_ack_s = 1'b0;
            end
            wait_cnt++;
        end else begin
            m_ack_s  = 1'b0;
            wait_cnt = 0;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) tick();
        rst = 1'b1;
    endtask

    task automatic txn(input string tag, input int ch, input logic wre, input logic [15:0] adr,
                       input logic [15:0] dto, input int dly, input logic exp_err,
                       input logic [15:0] exp_dti);
        int n;
        logic [1:0] want;
        want = 2'b01 << ch;
        cur_dly = dly;
        req_adr[ch] = adr;
        req_dto[ch] = dto;
        req_wre[ch] = wre;
        req_stb[ch] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                chk({tag, "_gnt"}, ifa.gnt, want);
                chk({tag, "_m_adr"}, ifa.m_adr, adr);
                chk({tag, "_m_wre"}, ifa.m_wre, wre);
            end
        end while ((ifa.c_ack | ifa.c_err) == 2'b00 && n < 20);
        chk({tag, "_latency"}, n, exp_err ? 5 : dly + 2);
        chk({tag, "_ack"}, ifa.c_ack, exp_err ? 2'b00 : want);
        chk({tag, "_err"}, ifa.c_err, exp_err ? want : 2'b00);
        chk({tag, "_dti"}, ifa.c_dti, exp_dti);
        chk({tag, "_m_stb_low"}, ifa.m_stb, 1'b0);
        req_stb[ch] = 1'b0;
        tick();
        chk({tag, "_ena_next"}, ifa.ena, 1'b1);
        chk({tag, "_idle_gnt"}, ifa.gnt, 2'b00);
        chk({tag, "_pulse_once"}, ifa.c_ack | ifa.c_err, 2'b00);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [8];
        logic [1:0]  ga [4];
        logic [1:0]  gb [4];
        logic [1:0]  exp_rr [4];
        logic [1:0]  pa, pb, a, e, g;
        int          na, nb, n;
        int          busy, last_m, w, blen, max_blen, max_wait, n_grants;
        int          wt [2];
        logic [7:0]  exp_a;
        logic        exp_w, exp_ok;
        logic [15:0] exp_d;

        req_adr[0] = 16'h0; req_adr[1] = 16'h0;
        req_dto[0] = 16'h0; req_dto[1] = 16'h0;
        for (int i = 0; i < 256; i++) smem[i] = 16'h0;

        // Reset with both strobes high, then contention with an instant slave
        req_stb = 2'b11;
        rst = 1'b0;
        tick();
        tick();
        chk("rst_gnt", ifa.gnt, 2'b00);
        chk("rst_m_stb", ifa.m_stb, 1'b0);
        chk("rst_ack_err", {ifa.c_ack, ifa.c_err}, 4'h0);
        chk("rst_m_adr", ifa.m_adr, 16'h0);
        chk("rst_c_dti", ifa.c_dti, 16'h0);
        chk("rst_fp_gnt", ifb.gnt, 2'b00);
        rst = 1'b1;
        exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;
        na = 0; nb = 0; pa = 2'b00; pb = 2'b00;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (ifa.gnt != 2'b00 && pa == 2'b00 && na < 4) begin ga[na] = ifa.gnt; na++; end
            if (ifb.gnt != 2'b00 && pb == 2'b00 && nb < 4) begin gb[nb] = ifb.gnt; nb++; end
            pa = ifa.gnt;
            pb = ifb.gnt;
        end
        chk("rr_grant_count", na, 4);
        chk("fp_grant_count", nb, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant%0d", i), ga[i], exp_rr[i]);
            chk($sformatf("fp_grant%0d", i), gb[i], 2'b01);
        end
        req_stb = 2'b00;
        repeat (6) tick();

        // Single transfers, including the ack/timeout boundary
        do_reset(1);
        smem[8'h23] = 16'hBEEF;
        vt[0] = '{0, 1'b1, 16'h0010, 16'h1111, 0, 1'b0, 16'h0000};
        vt[1] = '{1, 1'b0, 16'h0123, 16'h0000, 1, 1'b0, 16'hBEEF};
        vt[2] = '{1, 1'b1, 16'h0020, 16'hA5A5, 3, 1'b0, 16'hBEEF};
        vt[3] = '{0, 1'b0, 16'h0020, 16'h0000, 4, 1'b1, 16'hBEEF};
        vt[4] = '{0, 1'b0, 16'h0020, 16'h0000, 2, 1'b0, 16'hA5A5};
        vt[5] = '{1, 1'b1, 16'h0010, 16'h2222, 5, 1'b1, 16'hA5A5};
        vt[6] = '{0, 1'b0, 16'h0010, 16'h0000, 0, 1'b0, 16'h1111};
        vt[7] = '{1, 1'b0, 16'h0010, 16'h0000, 3, 1'b0, 16'h1111};
        for (int i = 0; i < 8; i++)
            txn($sformatf("vec%0d", i), vt[i].ch, vt[i].wre, vt[i].adr, vt[i].dto,
                vt[i].dly, vt[i].err, vt[i].dti);

        // m_ack while idle must be ignored
        ack_force = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("idle_ack_ignored", {ifa.gnt, ifa.c_ack, ifa.c_err, ifa.m_stb}, 7'h0);
        end
        ack_force = 1'b0;

        // Reset during a write must abort silently and restore the pointer
        txn("pre_rst", 0, 1'b0, 16'h0010, 16'h0000, 0, 1'b0, 16'h1111);
        cur_dly = 9;
        req_adr[1] = 16'h0030; req_dto[1] = 16'h7777; req_wre[1] = 1'b1; req_stb[1] = 1'b1;
        tick();
        tick();
        chk("mid_m_stb", ifa.m_stb, 1'b1);
        chk("mid_gnt", ifa.gnt, 2'b10);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_m_stb", ifa.m_stb, 1'b0);
        chk("mid_rst_gnt", ifa.gnt, 2'b00);
        chk("mid_rst_no_pulse", {ifa.c_ack, ifa.c_err}, 4'h0);
        req_wre = 2'b00;
        req_stb = 2'b11;
        cur_dly = 0;
        n = 0;
        do begin tick(); n++; end while (ifa.gnt == 2'b00 && n < 5);
        chk("ptr_reset_first", ifa.gnt, 2'b01);
        chk("mid_rst_no_write", smem[8'h30], 16'h0);
        req_stb = 2'b00;
        repeat (8) tick();

        // Randomised traffic against a transaction-level model
        do_reset(1);
        for (int i = 0; i < 256; i++) begin smem[i] = 16'h0; ref_mem[i] = 16'h0; end
        rand_dly = 1'b1;
        busy = -1; last_m = 1; blen = 0; max_blen = 0; max_wait = 0; n_grants = 0;
        wt[0] = 0; wt[1] = 0;
        exp_a = 8'h0; exp_w = 1'b0; exp_ok = 1'b0; exp_d = 16'h0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            a = ifa.c_ack; e = ifa.c_err; g = ifa.gnt;
            chk("rnd_ena", ifa.ena, &(~req_stb | a | e));
            if ((a | e) != 2'b00) begin
                if (busy < 0) begin
                    chk("rnd_stray_done", a | e, 2'b00);
                end else begin
                    chk("rnd_ack", a, exp_ok ? (2'b01 << busy) : 2'b00);
                    chk("rnd_err", e, exp_ok ? 2'b00 : (2'b01 << busy));
                    if (exp_ok && !exp_w) chk("rnd_rdata", ifa.c_dti, ref_mem[exp_a]);
                    if (exp_ok && exp_w) ref_mem[exp_a] = exp_d;
                    last_m = busy;
                    busy = -1;
                end
            end else if (g != 2'b00 && busy < 0) begin
                w = -1;
                for (int i = 0; i < 2; i++)
                    if (w < 0 && req_stb[(last_m + 1 + i) % 2]) w = (last_m + 1 + i) % 2;
                if (w < 0) begin
                    chk("rnd_grant_no_req", g, 2'b00);
                end else begin
                    chk("rnd_winner", g, 2'b01 << w);
                    chk("rnd_m_adr", ifa.m_adr, req_adr[w]);
                    chk("rnd_m_wre", ifa.m_wre, req_wre[w]);
                    chk("rnd_m_dto", ifa.m_dto, req_dto[w]);
                    busy = w; exp_a = req_adr[w][7:0]; exp_w = req_wre[w]; exp_d = req_dto[w];
                    exp_ok = (cur_dly <= 3);
                    blen = 0;
                    n_grants++;
                end
            end else if (busy >= 0) begin
                blen++;
                if (blen > max_blen) max_blen = blen;
                chk("rnd_hold_gnt", g, 2'b01 << busy);
                chk("rnd_hold_stb", ifa.m_stb, 1'b1);
            end
            for (int k = 0; k < 2; k++) begin
                if (req_stb[k]) begin
                    if (a[k] | e[k]) req_stb[k] = 1'b0;
                    else begin
                        wt[k]++;
                        if (wt[k] > max_wait) max_wait = wt[k];
                    end
                end else if (cyc < 3600 && $urandom_range(0, 2) == 0) begin
                    req_adr[k] = {12'h0, 4'($urandom)};
                    req_wre[k] = 1'($urandom);
                    req_dto[k] = 16'($urandom);
                    req_stb[k] = 1'b1;
                    wt[k] = 0;
                end
            end
        end
        chk("rnd_drained", busy, -1);
        chk("rnd_no_pending", req_stb, 2'b00);
        chk("rnd_busy_bound", max_blen <= 4, 1'b1);
        chk("rnd_wait_bound", max_wait <= 20, 1'b1);
        chk("rnd_enough_grants", n_grants > 100, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
